// File: rtl/dl_decoder_pipe.sv
// dl_decoder_pipe
//   Registered index decoder with valid/ready handshakes on both sides.
//   A two-entry store (output register O plus skid register S) gives one
//   transfer per cycle with fully registered outputs and an in_ready that
//   depends only on registered state.
//
//   Configuration macro: DL_DECODER_PIPE_THERMO_EN
//     defined     : in_mode selects one-hot (0) or thermometer (1) decode
//     not defined : in_mode is ignored, every decode is one-hot
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   index presented
//   in_ready   block can accept (skid entry empty)
//   in         index to decode, $clog2(OUTPUT_WIDTH) bits
//   in_mode    0 = one-hot, 1 = thermometer
//   out_valid  decoded word available
//   out_ready  consumer accepts
//   out        decoded word, OUTPUT_WIDTH bits
//   out_err    index was >= OUTPUT_WIDTH (word forced to zero)
module dl_decoder_pipe #(
   parameter int unsigned OUTPUT_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [$clog2(OUTPUT_WIDTH)-1:0] in,
   input  logic                            in_mode,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUTPUT_WIDTH-1:0]         out,
   output logic                            out_err
);

   localparam int unsigned INPUT_WIDTH = $clog2(OUTPUT_WIDTH);

   logic [31:0]             in_ext;
   logic [OUTPUT_WIDTH-1:0] dec_word;
   logic                    dec_err;

   logic [OUTPUT_WIDTH-1:0] o_word;
   logic                    o_err;
   logic                    o_valid;
   logic [OUTPUT_WIDTH-1:0] s_word;
   logic                    s_err;
   logic                    s_valid;

   logic                    in_xfer;
   logic                    o_load;

   assign in_ext = 32'(in);

`ifndef DL_DECODER_PIPE_THERMO_EN
   logic mode_unused;
   assign mode_unused = in_mode;
`endif

   // Decode is applied at accept time; out-of-range indices give a zero word.
   always_comb begin
      dec_word = '0;
      dec_err  = 1'b0;
      if (in_ext >= OUTPUT_WIDTH) begin
         dec_err = 1'b1;
      end else begin
         for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
`ifdef DL_DECODER_PIPE_THERMO_EN
            if (in_mode) begin
               dec_word[i] = (i <= in_ext);
            end else begin
               dec_word[i] = (i == in_ext);
            end
`else
            dec_word[i] = (i == in_ext);
`endif
         end
      end
   end

   assign in_ready = !s_valid;
   assign in_xfer  = in_valid && in_ready;
   assign o_load   = !o_valid || out_ready;

   // S only fills while O is stalled, so S.valid implies O.valid and an
   // input transfer can never coincide with S draining into O.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_word  <= '0;
         o_err   <= 1'b0;
         o_valid <= 1'b0;
         s_word  <= '0;
         s_err   <= 1'b0;
         s_valid <= 1'b0;
      end else if (o_load) begin
         if (s_valid) begin
            o_word  <= s_word;
            o_err   <= s_err;
            o_valid <= 1'b1;
            s_valid <= 1'b0;
         end else if (in_xfer) begin
            o_word  <= dec_word;
            o_err   <= dec_err;
            o_valid <= 1'b1;
         end else begin
            o_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         s_word  <= dec_word;
         s_err   <= dec_err;
         s_valid <= 1'b1;
      end
   end

   assign out       = o_word;
   assign out_err   = o_err;
   assign out_valid = o_valid;

endmodule

// File: tb/tb_dl_decoder_pipe.sv
// Bench for dl_decoder_pipe: two instances (32 and 20 outputs) checked every
// cycle against a two-entry FIFO model plus directed literal checks.
module tb_dl_decoder_pipe;

   logic       clk;
   logic       rst_n;
   logic       iv   [2];
   logic       ordy [2];
   logic       md   [2];
   logic [4:0] idx  [2];

   logic        rdy  [2];
   logic        ov   [2];
   logic        oerr [2];
   logic [31:0] outw [2];
   logic [31:0] out0;
   logic [19:0] out1;

`ifdef DL_DECODER_PIPE_THERMO_EN
   localparam bit THERMO = 1'b1;
`else
   localparam bit THERMO = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   // Model: each instance is a FIFO of capacity two holding {err, word}.
   logic [32:0] ent [2][2];
   int          cnt [2];
   bit          last_acc [2];

   dl_decoder_pipe #(.OUTPUT_WIDTH(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
      .in(idx[0]), .in_mode(md[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out(out0), .out_err(oerr[0])
   );

   dl_decoder_pipe #(.OUTPUT_WIDTH(20)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
      .in(idx[1]), .in_mode(md[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out(out1), .out_err(oerr[1])
   );

   assign outw[0] = out0;
   assign outw[1] = {12'd0, out1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [32:0] mdl(input int ow, input int v, input bit m);
      if (v >= ow) return {1'b1, 32'd0};
      if (m && THERMO) return {1'b0, 32'((64'd1 << (v + 1)) - 64'd1)};
      return {1'b0, 32'(64'd1 << v)};
   endfunction

   // Model update at each clock edge, flushed by asynchronous reset.
   initial begin
      cnt[0] = 0; cnt[1] = 0;
      last_acc[0] = 1'b0; last_acc[1] = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cnt[0] = 0; cnt[1] = 0;
            last_acc[0] = 1'b0; last_acc[1] = 1'b0;
         end else begin
            for (int k = 0; k < 2; k++) begin
               bit pop, acc;
               pop = (cnt[k] > 0) && ordy[k];
               acc = iv[k] && (cnt[k] < 2);
               if (pop) begin
                  ent[k][0] = ent[k][1];
                  cnt[k]--;
               end
               if (acc) begin
                  ent[k][cnt[k]] = mdl((k == 0) ? 32 : 20, int'(idx[k]), md[k]);
                  cnt[k]++;
               end
               last_acc[k] = acc;
            end
         end
      end
   end

   // Compare process: every cycle, handshake outputs and head-of-FIFO data.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(cnt[k] < 2));
            chk($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(cnt[k] > 0));
            if (cnt[k] > 0) begin
               chk($sformatf("out[%0d]", k), 64'(outw[k]), 64'(ent[k][0][31:0]));
               chk($sformatf("out_err[%0d]", k), 64'(oerr[k]), 64'(ent[k][0][32]));
            end
         end
      end
   end

   task automatic push(input int k, input int v, input bit m);
      int n;
      idx[k] = 5'(v);
      md[k]  = m;
      iv[k]  = 1'b1;
      n = 0;
      while (1) begin
         @(posedge clk);
         #1;
         if (last_acc[k]) break;
         n++;
         if (n > 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout[%0d] actual=no_accept required=accept", k);
            break;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; md[k] = 1'b0; idx[k] = '0;
      end
      #1;
      chk("reset_out_valid", 64'(ov[0]), 64'd0);
      chk("reset_out", 64'(out0), 64'd0);
      chk("reset_out_err", 64'(oerr[0]), 64'd0);
      chk("reset_in_ready", 64'(rdy[0]), 64'd1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // One-hot stream 0..31 with continuous acceptance.
      for (int v = 0; v < 32; v++) begin
         push(0, v, 1'b0);
         @(negedge clk);
         chk("stream_out", 64'(out0), 64'(32'd1 << v));
         chk("stream_err", 64'(oerr[0]), 64'd0);
         chk("stream_ready", 64'(rdy[0]), 64'd1);
      end
      iv[0] = 1'b0;

      // Thermometer vs one-hot for index 4.
      push(0, 4, 1'b1);
      iv[0] = 1'b0;
      @(negedge clk);
      chk("thermo_4", 64'(out0), THERMO ? 64'h1F : 64'h10);

      // Out-of-range and top in-range index on the 20-wide instance.
      push(1, 25, 1'b0);
      @(negedge clk);
      chk("oor_out", 64'(out1), 64'd0);
      chk("oor_err", 64'(oerr[1]), 64'd1);
      push(1, 19, 1'b0);
      iv[1] = 1'b0;
      @(negedge clk);
      chk("top_out", 64'(out1), 64'h80000);
      chk("top_err", 64'(oerr[1]), 64'd0);

      // Backpressure: 3 and 7 absorbed, 9 blocked until release.
      repeat (3) @(posedge clk);
      #2 ordy[0] = 1'b0;
      push(0, 3, 1'b0);
      push(0, 7, 1'b0);
      idx[0] = 5'd9;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("bp_hold_out", 64'(out0), 64'h8);
      chk("bp_in_ready", 64'(rdy[0]), 64'd0);
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("bp_second", 64'(out0), 64'h80);
      @(negedge clk);
      chk("bp_third", 64'(out0), 64'h200);
      chk("bp_ready_back", 64'(rdy[0]), 64'd1);
      iv[0] = 1'b0;
      repeat (2) @(posedge clk);

      // Randomized traffic on both instances.
      repeat (10000) begin
         @(posedge clk);
         #2;
         for (int k = 0; k < 2; k++) begin
            iv[k]   = ($urandom_range(0, 3) != 0);
            ordy[k] = ($urandom_range(0, 2) != 0);
            idx[k]  = 5'($urandom_range(0, 31));
            md[k]   = 1'($urandom_range(0, 1));
         end
      end

      // Fill O and S on both instances, then reset mid-cycle.
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
         ordy[k] = 1'b0; iv[k] = 1'b1; md[k] = 1'b0;
      end
      idx[0] = 5'd6;
      idx[1] = 5'd25;
      repeat (3) @(posedge clk);
      #4 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("arst_out_valid[%0d]", k), 64'(ov[k]), 64'd0);
         chk($sformatf("arst_out[%0d]", k), 64'(outw[k]), 64'd0);
         chk($sformatf("arst_out_err[%0d]", k), 64'(oerr[k]), 64'd0);
         chk($sformatf("arst_in_ready[%0d]", k), 64'(rdy[k]), 64'd1);
      end
      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1;
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'(ov[0]), 64'd0);
      push(0, 5, 1'b0);
      iv[0] = 1'b0;
      @(negedge clk);
      chk("post_rst_out", 64'(out0), 64'h20);
      chk("post_rst_err", 64'(oerr[0]), 64'd0);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
